hazard_ctrl: RTL and testbench

Pipeline hazard and flush scheduler for the 5-stage CPU. It watches register-file read addresses in ID, load destination in EX, branch resolution in MEM and return completion in WB. It drives stall/flush strobes to the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. An FSM sequences multi-cycle events: RET wait, halt drain and a watchdog.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM/WB observation inputs and the
// stall/flush strobes returned to the pipeline registers.
// The master side is the pipeline and the slave side is hazard_ctrl.
interface hazard_ctrl_if;
  logic [3:0] id_p0_addr;
  logic [3:0] id_p1_addr;
  logic       id_reg0_read;
  logic       id_reg1_read;
  logic       id_call;
  logic       id_ret;
  logic       id_hlt;
  logic       ex_mem_read;
  logic [3:0] ex_dst;
  logic       mem_branch_taken;
  logic       wb_ret;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       halted;
  logic       ret_timeout;

  modport master (
    output id_p0_addr, id_p1_addr, id_reg0_read, id_reg1_read, id_call,
           id_ret, id_hlt, ex_mem_read, ex_dst, mem_branch_taken, wb_ret,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush,
           halted, ret_timeout
  );

  modport slave (
    input  id_p0_addr, id_p1_addr, id_reg0_read, id_reg1_read, id_call,
           id_ret, id_hlt, ex_mem_read, ex_dst, mem_branch_taken, wb_ret,
    output pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush,
           halted, ret_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flush scheduler for the 5-stage CPU.
// Resolves load-use stalls, taken-branch flushes, CALL fetch drops and
// sequences RET wait (with watchdog) and halt drain through a small FSM.
// Strobes are combinational from state and inputs (0-cycle latency).
// Optional macro HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_ctrl #(
  parameter int RET_MAX = 6,
  parameter int DRAIN   = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  localparam int CMAX = (RET_MAX > DRAIN) ? RET_MAX : DRAIN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RET_MAX_C = CW'(RET_MAX);
  localparam logic [CW-1:0] DRAIN_C   = CW'(DRAIN);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_RET_WAIT   = 2'd1,
    S_HALT_DRAIN = 2'd2,
    S_HALTED     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ret_timeout_q, ret_timeout_d;
  logic          lu_s;
  logic          pc_stall_s, ifid_stall_s, ifid_flush_s, idex_flush_s;
  logic          exmem_flush_s, halted_s;

  // Load-use detect: ID reads the register an EX-stage load will write (r0 not exempt).
  always_comb begin
    lu_s = hz.ex_mem_read &
           ((hz.id_reg0_read & (hz.id_p0_addr == hz.ex_dst)) |
            (hz.id_reg1_read & (hz.id_p1_addr == hz.ex_dst)));
  end

  // Next-state, counter and raw strobe decode for every FSM state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ret_timeout_d = ret_timeout_q;
    pc_stall_s    = 1'b0;
    ifid_stall_s  = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    halted_s      = 1'b0;
    case (state_q)
      S_RUN: begin
        if (hz.mem_branch_taken) begin
          ifid_flush_s  = 1'b1;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
        end else if (lu_s) begin
          pc_stall_s   = 1'b1;
          ifid_stall_s = 1'b1;
          idex_flush_s = 1'b1;
        end else if (hz.id_ret) begin
          pc_stall_s   = 1'b1;
          ifid_flush_s = 1'b1;
          state_d      = S_RET_WAIT;
          cnt_d        = '0;
        end else if (hz.id_call) begin
          ifid_flush_s = 1'b1;
        end else if (hz.id_hlt) begin
          pc_stall_s   = 1'b1;
          ifid_flush_s = 1'b1;
          state_d      = S_HALT_DRAIN;
          cnt_d        = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RET_WAIT: begin
        pc_stall_s   = 1'b1;
        ifid_flush_s = 1'b1;
        if (hz.mem_branch_taken) begin
          // An older branch kills the RET; PC must take the branch target.
          pc_stall_s    = 1'b0;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
          state_d       = S_RUN;
          cnt_d         = '0;
        end else if (hz.wb_ret) begin
          pc_stall_s = 1'b0;
          state_d    = S_RUN;
          cnt_d      = '0;
        end else begin
          if (cnt_q < RET_MAX_C) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
          if (cnt_q >= (RET_MAX_C - CNT_ONE)) begin
            ret_timeout_d = 1'b1;
          end else begin
            ret_timeout_d = ret_timeout_q;
          end
        end
      end
      S_HALT_DRAIN: begin
        pc_stall_s   = 1'b1;
        ifid_flush_s = 1'b1;
        if (hz.mem_branch_taken) begin
          // Halt was speculative behind a taken branch.
          pc_stall_s    = 1'b0;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
          state_d       = S_RUN;
          cnt_d         = '0;
        end else if (cnt_q >= (DRAIN_C - CNT_ONE)) begin
          state_d = S_HALTED;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HALTED: begin
        pc_stall_s   = 1'b1;
        ifid_stall_s = 1'b1;
        idex_flush_s = 1'b1;
        halted_s     = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output drive: while rst is low all three pipeline registers load bubbles.
  always_comb begin
    hz.pc_stall    = rst & pc_stall_s;
    hz.ifid_stall  = rst & ifid_stall_s;
    hz.ifid_flush  = ~rst | ifid_flush_s;
    hz.idex_flush  = ~rst | idex_flush_s;
    hz.exmem_flush = ~rst | exmem_flush_s;
    hz.halted      = rst & halted_s;
    hz.ret_timeout = ret_timeout_q;
  end

  // State, counter and sticky watchdog flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_RUN;
      cnt_q         <= '0;
      ret_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ret_timeout_q <= ret_timeout_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  // Saturating perf counter increments.
  always_comb begin
    if (hz.pc_stall && (state_q != S_HALTED) && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (rst && hz.exmem_flush && (flush_events_q != {CNT_W{1'b1}})) begin
      flush_events_d = flush_events_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_events_d = flush_events_q;
    end
  end

  // Perf counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl. Each vector pushes its expected
// strobe word; a monitor compares on the falling edge.
// Word order: {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush, halted, ret_timeout}
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  hazard_ctrl_if hz();

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
  hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz),
                   .stall_cycles(stall_cycles), .flush_events(flush_events));
`else
  hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz));
`endif

  typedef struct {
    logic [6:0] v;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] E0   = 7'b000_0000;
  localparam logic [6:0] ERST = 7'b001_1100;
  localparam logic [6:0] ELU  = 7'b110_1000;
  localparam logic [6:0] EBR  = 7'b001_1100;
  localparam logic [6:0] ECAL = 7'b001_0000;
  localparam logic [6:0] EWT  = 7'b101_0000;
  localparam logic [6:0] EWB  = 7'b001_0000;
  localparam logic [6:0] EHLT = 7'b110_1010;
  localparam logic [6:0] ETO  = 7'b000_0001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [3:0] p0, input logic [3:0] p1,
                      input logic r0, input logic r1, input logic call,
                      input logic ret, input logic hlt, input logic mr,
                      input logic [3:0] dst, input logic br, input logic wb,
                      input logic [6:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst                 = r;
    hz.id_p0_addr       = p0;
    hz.id_p1_addr       = p1;
    hz.id_reg0_read     = r0;
    hz.id_reg1_read     = r1;
    hz.id_call          = call;
    hz.id_ret           = ret;
    hz.id_hlt           = hlt;
    hz.ex_mem_read      = mr;
    hz.ex_dst           = dst;
    hz.mem_branch_taken = br;
    hz.wb_ret           = wb;
    x.v  = e;
    x.nm = nm;
    exp_q.push_back(x);
  endtask

  task automatic idle(input logic [6:0] e, input string nm);
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, e, nm);
  endtask

  task automatic reset_cyc(input logic [6:0] e, input string nm);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, e, nm);
  endtask

  // Monitor: pop one expectation per cycle and compare on the falling edge.
  initial begin
    exp_t x;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        act = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_flush,
               hz.exmem_flush, hz.halted, hz.ret_timeout};
        checks++;
        if (act !== x.v) begin
          errors++;
          $display("FAIL %s: got %b expected %b", x.nm, act, x.v);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    hz.id_p0_addr = 4'h0; hz.id_p1_addr = 4'h0;
    hz.id_reg0_read = 1'b0; hz.id_reg1_read = 1'b0;
    hz.id_call = 1'b0; hz.id_ret = 1'b0; hz.id_hlt = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_dst = 4'h0;
    hz.mem_branch_taken = 1'b0; hz.wb_ret = 1'b0;

    reset_cyc(ERST, "reset0");
    reset_cyc(ERST, "reset1");
    idle(E0, "idle_after_reset");

    // Load-use, port 0 and port 1, r0 not exempt, unused port ignored
    step(1'b1, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, ELU, "lu_p0");
    idle(E0, "lu_p0_release");
    step(1'b1, 4'h0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, ELU, "lu_p1");
    step(1'b1, 4'h0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, E0,  "no_lu_addr_diff");
    step(1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, ELU, "lu_r0");
    step(1'b1, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, E0,  "no_lu_unread");
    step(1'b1, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, E0,  "no_lu_not_load");

    // Branch beats load-use; load-use beats ret
    step(1'b1, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0, EBR, "br_over_lu");
    idle(E0, "br_stays_run");
    step(1'b1, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, ELU, "lu_over_ret");
    idle(E0, "ret_deferred_run");

    // CALL drops fall-through fetch for one cycle
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ECAL, "call");
    idle(E0, "call_done");

    // RET with wb_ret after 3 stalled cycles
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, EWT, "ret_entry");
    idle(EWT, "ret_wait1");
    idle(EWT, "ret_wait2");
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, EWB, "ret_wb");
    idle(E0, "ret_back_run");

    // RET killed by older branch
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, EWT, "ret2_entry");
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, EBR, "ret2_br_kill");
    idle(E0, "ret2_run");

    // RET watchdog: six waits without wb_ret set the sticky flag
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, EWT, "rto_entry");
    for (int i = 0; i < 6; i++) idle(EWT, "rto_wait");
    idle(EWT | ETO, "rto_set");
    idle(EWT | ETO, "rto_sticky");
    reset_cyc(ERST | ETO, "rto_reset_cycle");
    idle(E0, "rto_cleared_run");

    // Halt drains 3 cycles then holds
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, EWT, "hlt_entry");
    idle(EWT, "drain0");
    idle(EWT, "drain1");
    idle(EWT, "drain2");
    idle(EHLT, "halted0");
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, EHLT, "halted_ignores_br");
    idle(EHLT, "halted2");
    reset_cyc(ERST, "halt_reset");
    idle(E0, "halt_reset_run");

    // Halt cancelled by a branch in drain cycle 2
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, EWT, "hlt2_entry");
    idle(EWT, "hlt2_drain0");
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, EBR, "hlt2_br_cancel");
    for (int i = 0; i < 4; i++) idle(E0, "hlt2_not_halted");

    // Reset mid-drain aborts to RUN
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, EWT, "hlt3_entry");
    reset_cyc(ERST, "hlt3_reset");
    for (int i = 0; i < 4; i++) idle(E0, "hlt3_run");

    // Perf segment: two load-use stalls plus one branch flush
    reset_cyc(ERST, "perf_reset");
    step(1'b1, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, ELU, "perf_lu1");
    idle(E0, "perf_gap");
    step(1'b1, 4'h0, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, ELU, "perf_lu2");
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, EBR, "perf_br");
    idle(E0, "perf_tail");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cycles !== 16'd2) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected 2", stall_cycles);
    end
    checks++;
    if (flush_events !== 16'd1) begin
      errors++;
      $display("FAIL flush_events: got %0d expected 1", flush_events);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
